// File: rtl/gmii_pkg.sv
// Shared types and GMII byte constants for the two-source TX scheduler.
package gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_IFG   = 3'd5
  } tx_state_e;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;
  localparam logic [7:0] GMII_IDLE     = 8'h00;

  // One cycle worth of GMII/status output, registered as a unit.
  typedef struct packed {
    logic       ctrl;
    logic       err;
    logic [7:0] data;
    logic       sof;
    logic       abort;
  } gmii_word_t;

  function automatic gmii_word_t gmii_word(input logic ctrl, input logic err,
                                           input logic [7:0] data);
    gmii_word_t w;
    w.ctrl  = ctrl;
    w.err   = err;
    w.data  = data;
    w.sof   = 1'b0;
    w.abort = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/gmii_tx_sched_if.sv
// Byte-stream source handshake: a source is the master, the scheduler the slave.
interface gmii_tx_sched_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/gmii_tx_arb2.sv
// Two-way arbiter: fixed src0 priority or round-robin, pointer advances on grant.
module gmii_tx_arb2 #(
  parameter int PRIO_MODE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt,
  output logic gnt_idx
);

  // rr_ptr holds the preferred source for the next contested grant.
  logic rr_ptr;

  // Winner selection; only consulted when en is high.
  always_comb begin
    gnt_idx = 1'b0;
    if (PRIO_MODE != 0) begin
      gnt_idx = !req0 && req1;
    end else if (req0 && req1) begin
      gnt_idx = rr_ptr;
    end else begin
      gnt_idx = req1;
    end
  end

  assign gnt = en && (req0 || req1);

  // After serving a source, prefer the other one next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (gnt) begin
      rr_ptr <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// Two-source GMII TX scheduler: preamble, SFD, payload, IFG per frame.
//   state    | meaning
//   IDLE     | arbitrate; grant emits the first preamble byte
//   PRE      | remaining preamble bytes
//   SFD      | emit 0xD5 with tx_sof
//   DATA     | forward accepted bytes; underrun/overlength abort
//   DRAIN    | discard the rest of an aborted frame up to last
//   IFG      | enforce the inter-frame gap
module gmii_tx_sched
  import gmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MAX_LEN      = 1522,
  parameter int PRIO_MODE    = 1
) (
  input  logic             gmii_txclk,
  input  logic             rst_n,
  gmii_tx_sched_if.slave   s0,
  gmii_tx_sched_if.slave   s1,
  output logic             gmii_txctrl,
  output logic             gmii_txerr,
  output logic [7:0]       gmii_txdata,
  output logic             tx_sof,
  output logic             tx_src,
  output logic             tx_abort
);

  // The grant cycle already emits preamble byte one, so PRE covers the rest.
  localparam logic [3:0]  PRE_LOAD = (PREAMBLE_LEN >= 2) ? 4'(PREAMBLE_LEN - 2) : 4'd0;
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_LEN);

  tx_state_e   state, state_nxt;
  logic [3:0]  pre_cnt, pre_nxt;
  logic [7:0]  ifg_cnt, ifg_nxt;
  logic [15:0] byte_cnt, byte_nxt;
  logic        src, src_nxt;
  gmii_word_t  out_nxt;

  logic        arb_en, arb_gnt, arb_idx;
  logic        sel_valid, sel_last;
  logic [7:0]  sel_data;
  logic        in_frame;

  assign arb_en = (state == ST_IDLE);

  gmii_tx_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk     (gmii_txclk),
    .rst_n   (rst_n),
    .req0    (s0.valid),
    .req1    (s1.valid),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign sel_valid = src ? s1.valid : s0.valid;
  assign sel_last  = src ? s1.last  : s0.last;
  assign sel_data  = src ? s1.data  : s0.data;

  // Ready depends only on state and the latched grant, never on valid.
  assign in_frame = (state == ST_DATA) || (state == ST_DRAIN);
  assign s0.ready = in_frame && !src;
  assign s1.ready = in_frame && src;
  assign tx_src   = src;

  // Next-state, counters and next output word.
  always_comb begin
    state_nxt = state;
    pre_nxt   = pre_cnt;
    ifg_nxt   = ifg_cnt;
    byte_nxt  = byte_cnt;
    src_nxt   = src;
    out_nxt   = gmii_word(1'b0, 1'b0, GMII_IDLE);
    case (state)
      ST_IDLE: begin
        if (arb_gnt) begin
          src_nxt  = arb_idx;
          byte_nxt = 16'd0;
          out_nxt  = gmii_word(1'b1, 1'b0, GMII_PREAMBLE);
          if (PREAMBLE_LEN > 1) begin
            state_nxt = ST_PRE;
            pre_nxt   = PRE_LOAD;
          end else begin
            state_nxt = ST_SFD;
          end
        end
      end
      ST_PRE: begin
        out_nxt = gmii_word(1'b1, 1'b0, GMII_PREAMBLE);
        if (pre_cnt == 4'd0) begin
          state_nxt = ST_SFD;
        end else begin
          pre_nxt = pre_cnt - 4'd1;
        end
      end
      ST_SFD: begin
        out_nxt     = gmii_word(1'b1, 1'b0, GMII_SFD);
        out_nxt.sof = 1'b1;
        state_nxt   = ST_DATA;
      end
      ST_DATA: begin
        if (byte_cnt == MAX_CNT || !sel_valid) begin
          // Overlength or underrun: one error byte, then drop the remainder.
          out_nxt       = gmii_word(1'b1, 1'b1, GMII_IDLE);
          out_nxt.abort = 1'b1;
          if (sel_valid && sel_last) begin
            state_nxt = ST_IFG;
            ifg_nxt   = 8'd0;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          out_nxt = gmii_word(1'b1, 1'b0, sel_data);
          if (byte_cnt != 16'hFFFF) begin
            byte_nxt = byte_cnt + 16'd1;
          end
          if (sel_last) begin
            state_nxt = ST_IFG;
            ifg_nxt   = 8'd0;
          end
        end
      end
      ST_DRAIN: begin
        if (sel_valid && sel_last) begin
          state_nxt = ST_IFG;
          ifg_nxt   = 8'd0;
        end
      end
      ST_IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          ifg_nxt = ifg_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, counters and the latched grant.
  always_ff @(posedge gmii_txclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IFG;
      pre_cnt  <= 4'd0;
      ifg_cnt  <= 8'd0;
      byte_cnt <= 16'd0;
      src      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pre_cnt  <= pre_nxt;
      ifg_cnt  <= ifg_nxt;
      byte_cnt <= byte_nxt;
      src      <= src_nxt;
    end
  end

  // Registered GMII and status outputs.
  always_ff @(posedge gmii_txclk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_txctrl <= 1'b0;
      gmii_txerr  <= 1'b0;
      gmii_txdata <= GMII_IDLE;
      tx_sof      <= 1'b0;
      tx_abort    <= 1'b0;
    end else begin
      gmii_txctrl <= out_nxt.ctrl;
      gmii_txerr  <= out_nxt.err;
      gmii_txdata <= out_nxt.data;
      tx_sof      <= out_nxt.sof;
      tx_abort    <= out_nxt.abort;
    end
  end

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench: dut_a is fixed-priority, dut_b round-robin; both MAX_LEN=100.
module tb_gmii_tx_sched;

  localparam int LOGN = 4096;

  logic gmii_txclk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #4 gmii_txclk = ~gmii_txclk;

  // Interval index: value of cyc between one rising edge and the next.
  always @(posedge gmii_txclk) cyc <= cyc + 1;

  gmii_tx_sched_if a0 ();
  gmii_tx_sched_if a1 ();
  gmii_tx_sched_if b0 ();
  gmii_tx_sched_if b1 ();

  logic       a_ctrl, a_err, a_sof, a_abort, a_src;
  logic [7:0] a_data;
  logic       b_ctrl, b_err, b_sof, b_abort, b_src;
  logic [7:0] b_data;

  gmii_tx_sched #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MAX_LEN(100), .PRIO_MODE(1)) dut_a (
    .gmii_txclk (gmii_txclk), .rst_n (rst_n), .s0 (a0), .s1 (a1),
    .gmii_txctrl (a_ctrl), .gmii_txerr (a_err), .gmii_txdata (a_data),
    .tx_sof (a_sof), .tx_src (a_src), .tx_abort (a_abort));

  gmii_tx_sched #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MAX_LEN(100), .PRIO_MODE(0)) dut_b (
    .gmii_txclk (gmii_txclk), .rst_n (rst_n), .s0 (b0), .s1 (b1),
    .gmii_txctrl (b_ctrl), .gmii_txerr (b_err), .gmii_txdata (b_data),
    .tx_sof (b_sof), .tx_src (b_src), .tx_abort (b_abort));

  // Output trace per interval: flags = {ctrl, err, sof, abort}.
  logic [3:0] lg_flags [2][LOGN];
  logic [7:0] lg_data  [2][LOGN];
  logic       lg_src   [2][LOGN];
  logic       lg_rdy   [4][LOGN];

  // Sample outputs mid-cycle into the trace.
  always @(negedge gmii_txclk) begin
    if (cyc < LOGN) begin
      lg_flags[0][cyc] <= {a_ctrl, a_err, a_sof, a_abort};
      lg_data[0][cyc]  <= a_data;
      lg_src[0][cyc]   <= a_src;
      lg_flags[1][cyc] <= {b_ctrl, b_err, b_sof, b_abort};
      lg_data[1][cyc]  <= b_data;
      lg_src[1][cyc]   <= b_src;
      lg_rdy[0][cyc]   <= a0.ready;
      lg_rdy[1][cyc]   <= a1.ready;
      lg_rdy[2][cyc]   <= b0.ready;
      lg_rdy[3][cyc]   <= b1.ready;
    end
  end

  // Source byte queues: {gap, last, data}; a gap entry holds valid low one cycle.
  logic [9:0] qa0 [$];
  logic [9:0] qa1 [$];
  logic [9:0] qb0 [$];
  logic [9:0] qb1 [$];
  bit         hs [4];

  function automatic int qsize(input int k);
    case (k)
      0: return qa0.size();
      1: return qa1.size();
      2: return qb0.size();
      default: return qb1.size();
    endcase
  endfunction

  function automatic logic [9:0] qfront(input int k);
    case (k)
      0: return qa0[0];
      1: return qa1[0];
      2: return qb0[0];
      default: return qb1[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(qa0.pop_front());
      1: void'(qa1.pop_front());
      2: void'(qb0.pop_front());
      default: void'(qb1.pop_front());
    endcase
  endtask

  task automatic qpush(input int k, input logic [9:0] e);
    case (k)
      0: qa0.push_back(e);
      1: qa1.push_back(e);
      2: qb0.push_back(e);
      default: qb1.push_back(e);
    endcase
  endtask

  task automatic push_bytes(input int k, input int n, input int base, input bit with_last);
    for (int i = 0; i < n; i++) qpush(k, {1'b0, (with_last && i == n - 1), 8'(base + i)});
  endtask

  task automatic push_gap(input int k, input int n);
    for (int i = 0; i < n; i++) qpush(k, 10'h200);
  endtask

  task automatic set_src(input int k, input logic v, input logic [7:0] d, input logic l);
    case (k)
      0: begin a0.valid = v; a0.data = d; a0.last = l; end
      1: begin a1.valid = v; a1.data = d; a1.last = l; end
      2: begin b0.valid = v; b0.data = d; b0.last = l; end
      default: begin b1.valid = v; b1.data = d; b1.last = l; end
    endcase
  endtask

  function automatic logic get_rdy(input int k);
    case (k)
      0: return a0.ready;
      1: return a1.ready;
      2: return b0.ready;
      default: return b1.ready;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) > 0 && n < budget) begin
      @(negedge gmii_txclk);
      n++;
    end
    chk({tag, "_done"}, 32'(n < budget), 32'd1);
    repeat (20) @(negedge gmii_txclk);
  endtask

  // Checks one frame in the trace of DUT u starting at or after idx.
  // exp_start >= 0 demands idle from idx up to exp_start and the preamble there.
  task automatic chk_frame(input int u, input string tag, inout int idx, input int exp_start,
                           input bit exp_src, input int n, input int base, input bit aborted,
                           output int start);
    int s;
    s = -1;
    if (exp_start < 0) begin
      for (int j = idx; j < cyc && j < LOGN && s < 0; j++) if (lg_flags[u][j][3] === 1'b1) s = j;
      chk({tag, "_found"}, 32'(s >= 0), 32'd1);
    end else begin
      for (int j = idx; j < exp_start; j++)
        chk($sformatf("%s_idle%0d", tag, j - idx), 32'({lg_flags[u][j], lg_data[u][j]}), 32'd0);
      s = exp_start;
    end
    start = (s < 0) ? idx : s;
    if (s < 0 || s + 10 + n >= LOGN) begin
      chk({tag, "_inlog"}, 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_pre%0d", tag, i), 32'({lg_flags[u][s+i], lg_data[u][s+i]}), 32'h855);
    chk({tag, "_sfd"}, 32'({lg_flags[u][s+7], lg_data[u][s+7], lg_src[u][s+7]}),
        32'({4'b1010, 8'hD5, exp_src}));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'({lg_flags[u][s+8+i], lg_data[u][s+8+i]}),
          32'({4'b1000, 8'(base + i)}));
    idx = s + 8 + n;
    if (aborted) begin
      chk({tag, "_abort"}, 32'({lg_flags[u][idx], lg_data[u][idx], lg_src[u][idx]}),
          32'({4'b1101, 8'h00, exp_src}));
      idx++;
    end
  endtask

  initial begin
    int idx, st, f, a, b, rel, sof_at;
    bit found;

    for (int k = 0; k < 4; k++) set_src(k, 1'b0, 8'h00, 1'b0);

    // Source drivers: present at falling edge, pop on handshake at rising edge.
    fork
      forever begin
        @(negedge gmii_txclk);
        for (int k = 0; k < 4; k++) begin
          logic [9:0] e;
          hs[k] = 1'b0;
          if (qsize(k) == 0) begin
            set_src(k, 1'b0, 8'h00, 1'b0);
          end else begin
            e = qfront(k);
            if (e[9]) begin
              set_src(k, 1'b0, 8'h00, 1'b0);
              qpop(k);
            end else begin
              set_src(k, 1'b1, e[7:0], e[8]);
              hs[k] = get_rdy(k);
            end
          end
        end
        @(posedge gmii_txclk);
        for (int k = 0; k < 4; k++) if (hs[k] && qsize(k) > 0) qpop(k);
      end
    join_none

    // Reset values.
    repeat (3) @(negedge gmii_txclk);
    chk("rst_a_outs", 32'({a_ctrl, a_err, a_sof, a_abort, a_src, a_data}), 32'd0);
    chk("rst_b_outs", 32'({b_ctrl, b_err, b_sof, b_abort, b_src, b_data}), 32'd0);
    chk("rst_rdy", 32'({a0.ready, a1.ready, b0.ready, b1.ready}), 32'd0);

    // Single 64-byte src1 frame queued before reset release.
    push_bytes(1, 64, 8'h00, 1'b1);
    rel = cyc;
    rst_n = 1'b1;
    wait_drain("a_single", 400);
    idx = rel;
    chk_frame(0, "a_single", idx, -1, 1'b1, 64, 0, 1'b0, f);
    chk("a_rel_gap", 32'((f - rel) >= 12), 32'd1);
    for (int i = 0; i < 12; i++)
      chk($sformatf("a_single_ifg%0d", i), 32'({lg_flags[0][idx+i], lg_data[0][idx+i]}), 32'd0);

    // Fixed priority: three src0 frames go before a waiting src1 frame.
    @(negedge gmii_txclk);
    push_bytes(0, 8, 8'hA0, 1'b1);
    push_bytes(0, 8, 8'hB0, 1'b1);
    push_bytes(0, 8, 8'hC0, 1'b1);
    push_bytes(1, 8, 8'hD0, 1'b1);
    st = cyc;
    wait_drain("a_prio", 600);
    idx = st;
    chk_frame(0, "a_prio0", idx, -1, 1'b0, 8, 8'hA0, 1'b0, f);
    chk_frame(0, "a_prio1", idx, idx + 12, 1'b0, 8, 8'hB0, 1'b0, f);
    chk_frame(0, "a_prio2", idx, idx + 12, 1'b0, 8, 8'hC0, 1'b0, f);
    chk_frame(0, "a_prio3", idx, idx + 12, 1'b1, 8, 8'hD0, 1'b0, f);

    // src0 underruns after 10 bytes; src1 sends 150 bytes into MAX_LEN=100.
    @(negedge gmii_txclk);
    push_bytes(0, 10, 8'h10, 1'b0);
    push_gap(0, 3);
    push_bytes(0, 5, 8'h60, 1'b1);
    push_bytes(1, 150, 8'h00, 1'b1);
    st = cyc;
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge gmii_txclk);
      if (qsize(1) < 140) found = 1'b1;
    end
    chk("a_src1_started", 32'(found), 32'd1);
    push_bytes(0, 4, 8'hE0, 1'b1);
    wait_drain("a_abort", 800);
    idx = st;
    chk_frame(0, "a_under", idx, -1, 1'b0, 10, 8'h10, 1'b1, f);
    a = idx - 1;
    // Drain: gap occupies 3 cycles from the error cycle - 1, then 5 bytes.
    for (int i = 0; i < 7; i++)
      chk($sformatf("a_under_rdy%0d", i), 32'(lg_rdy[0][a+i]), 32'd1);
    chk("a_under_rdy_end", 32'(lg_rdy[0][a+7]), 32'd0);
    chk("a_under_rdy1", 32'(lg_rdy[1][a]), 32'd0);
    // Last drained byte accepted at a+6; next preamble 2+12 cycles later.
    chk_frame(0, "a_ovl", idx, a + 20, 1'b1, 100, 8'h00, 1'b1, f);
    b = idx - 1;
    // Bytes 101..150 drained; last one accepted at b+48.
    chk_frame(0, "a_after", idx, b + 62, 1'b0, 4, 8'hE0, 1'b0, f);

    // Round-robin: both sources request two 60-byte frames each.
    @(negedge gmii_txclk);
    push_bytes(2, 60, 8'h00, 1'b1);
    push_bytes(2, 60, 8'h80, 1'b1);
    push_bytes(3, 60, 8'h40, 1'b1);
    push_bytes(3, 60, 8'hC0, 1'b1);
    st = cyc;
    wait_drain("b_rr", 800);
    idx = st;
    chk_frame(1, "b_rr0", idx, -1, 1'b0, 60, 8'h00, 1'b0, f);
    chk_frame(1, "b_rr1", idx, idx + 12, 1'b1, 60, 8'h40, 1'b0, f);
    chk_frame(1, "b_rr2", idx, idx + 12, 1'b0, 60, 8'h80, 1'b0, f);
    chk_frame(1, "b_rr3", idx, idx + 12, 1'b1, 60, 8'hC0, 1'b0, f);

    // Reset asserted while payload byte 20 is on the wire.
    @(negedge gmii_txclk);
    push_bytes(0, 40, 8'h20, 1'b1);
    found = 1'b0;
    sof_at = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge gmii_txclk);
      if (a_sof === 1'b1) begin found = 1'b1; sof_at = cyc; end
    end
    chk("a_mid_sof", 32'(found), 32'd1);
    repeat (20) @(negedge gmii_txclk);
    chk("a_mid_b20", 32'({a_ctrl, a_data}), 32'h133);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      while (qsize(k) > 0) qpop(k);
      set_src(k, 1'b0, 8'h00, 1'b0);
    end
    #1;
    chk("a_mid_rst", 32'({a_ctrl, a_err, a_sof, a_abort, a_data}), 32'd0);
    repeat (3) @(negedge gmii_txclk);
    push_bytes(0, 8, 8'h90, 1'b1);
    rel = cyc;
    rst_n = 1'b1;
    wait_drain("a_rerst", 300);
    idx = rel;
    chk_frame(0, "a_rerst", idx, -1, 1'b0, 8, 8'h90, 1'b0, f);
    chk("a_rerst_gap", 32'((f - rel) >= 12), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
